// File: rtl/alu_bist_checker.sv
// BIST sequencer/checker for the W-bit logic unit: sweeps every {op,a,b} vector
// over a valid/ready handshake and scores each returned result against a golden model.
`timescale 1ns/1ps
module alu_bist_checker #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 vec_valid,
  input  logic                 vec_ready,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic [1:0]           op_out,
  input  logic                 res_valid,
  input  logic [WIDTH-1:0]     res_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic                 timeout_seen,
  output logic [2*WIDTH+1:0]   first_fail_idx,
  output logic [WIDTH-1:0]     first_fail_data
);

  localparam int unsigned IW    = 2 * WIDTH + 2;
  localparam logic [7:0]  TMO_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             vec_valid_q, busy_q, done_q;
  logic [IW-1:0]    idx_q, idx_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic [15:0]      err_q, err_d;
  logic             tmo_q, tmo_d;
  logic             pass_q, pass_d;
  logic [IW-1:0]    ffi_q, ffi_d;
  logic [WIDTH-1:0] ffd_q, ffd_d;

  logic [1:0]       cur_op_s;
  logic [WIDTH-1:0] cur_a_s, cur_b_s, expected_s;
  logic             resp_s, tmo_hit_s, fail_s, last_s;

  function automatic logic [WIDTH-1:0] golden(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  assign cur_op_s   = idx_q[IW-1 -: 2];
  assign cur_a_s    = idx_q[2*WIDTH-1 -: WIDTH];
  assign cur_b_s    = idx_q[WIDTH-1:0];
  assign expected_s = golden(cur_op_s, cur_a_s, cur_b_s);

  // A response on the cycle the count reaches TIMEOUT wins over the timeout.
  assign resp_s    = (state_q == S_WAIT) && res_valid;
  assign tmo_hit_s = (state_q == S_WAIT) && !res_valid && (tcnt_q == TMO_C);
  assign fail_s    = tmo_hit_s || (resp_s && (res_data != expected_s));
  assign last_s    = &idx_q;

  // State register plus registered status flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_valid_q <= (state_d == S_ISSUE);
      busy_q      <= (state_d == S_ISSUE) || (state_d == S_WAIT);
      done_q      <= (state_d == S_DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ISSUE;
        else       state_d = S_IDLE;
      end
      S_ISSUE: begin
        if (vec_ready) state_d = S_WAIT;
        else           state_d = S_ISSUE;
      end
      S_WAIT: begin
        if (resp_s || tmo_hit_s) state_d = last_s ? S_DONE : S_ISSUE;
        else                     state_d = S_WAIT;
      end
      S_DONE: begin
        if (start) state_d = S_ISSUE;
        else       state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: vector index, timeout counter and pass/fail status.
  always_comb begin
    idx_d  = idx_q;
    tcnt_d = tcnt_q;
    err_d  = err_q;
    tmo_d  = tmo_q;
    pass_d = pass_q;
    ffi_d  = ffi_q;
    ffd_d  = ffd_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d  = '0;
          tcnt_d = 8'd0;
          err_d  = 16'd0;
          tmo_d  = 1'b0;
          pass_d = 1'b0;
          ffi_d  = '0;
          ffd_d  = '0;
        end else begin
          idx_d = idx_q;
        end
      end
      S_ISSUE: begin
        if (vec_ready) tcnt_d = 8'd0;
        else           tcnt_d = tcnt_q;
      end
      S_WAIT: begin
        if (resp_s || tmo_hit_s) begin
          if (fail_s) begin
            if (err_q == 16'd0) begin
              ffi_d = idx_q;
              ffd_d = tmo_hit_s ? '0 : res_data;
            end else begin
              ffi_d = ffi_q;
            end
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            else                   err_d = err_q;
            if (tmo_hit_s) tmo_d = 1'b1;
            else           tmo_d = tmo_q;
          end else begin
            err_d = err_q;
          end
          if (last_s) pass_d = (err_q == 16'd0) && !fail_s;
          else        idx_d  = idx_q + IW'(1);
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: idx_d = idx_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      tcnt_q <= 8'd0;
      err_q  <= 16'd0;
      tmo_q  <= 1'b0;
      pass_q <= 1'b0;
      ffi_q  <= '0;
      ffd_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
      tmo_q  <= tmo_d;
      pass_q <= pass_d;
      ffi_q  <= ffi_d;
      ffd_q  <= ffd_d;
    end
  end

  assign vec_valid       = vec_valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign a_out           = cur_a_s;
  assign b_out           = cur_b_s;
  assign op_out          = cur_op_s;
  assign err_count       = err_q;
  assign timeout_seen    = tmo_q;
  assign first_fail_idx  = ffi_q;
  assign first_fail_data = ffd_q;

endmodule

// File: tb/tb_alu_bist_checker.sv
// Bench for alu_bist_checker: a behavioural logic-unit responder with fault modes,
// a transaction-level reference of the checker, and per-cycle output comparison.
`timescale 1ns/1ps
module tb_alu_bist_checker;

  localparam int W   = 4;
  localparam int TMO = 15;
  localparam int IW  = 2 * W + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          vec_ready = 1'b0;
  logic          res_valid = 1'b0;
  logic [W-1:0]  res_data = '0;
  logic          vec_valid, busy, done, pass, timeout_seen;
  logic [W-1:0]  a_out, b_out, first_fail_data;
  logic [1:0]    op_out;
  logic [15:0]   err_count;
  logic [IW-1:0] first_fail_idx;

  alu_bist_checker #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .a_out(a_out), .b_out(b_out), .op_out(op_out),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .timeout_seen(timeout_seen), .first_fail_idx(first_fail_idx),
    .first_fail_data(first_fail_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [IW-1:0] v);
    logic [W-1:0] a, b, r;
    a = v[2*W-1:W];
    b = v[W-1:0];
    case (v[IW-1:IW-2])
      2'd0:    r = a & b;
      2'd1:    r = a | b;
      2'd2:    r = a ^ b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  // Responder modes
  logic fault_and0 = 1'b0, drop_not = 1'b0, hold_mode = 1'b0, stray_mode = 1'b0, rnd_mode = 1'b0;

  // Behavioural logic unit: drives vec_ready and res_valid/res_data on falling edges.
  initial begin : unit
    int           pend_cnt;
    int           hold_cnt;
    int           lat;
    logic [W-1:0] pend_data;
    logic [W-1:0] d;
    logic [IW-1:0] cur;
    pend_cnt = 0;
    hold_cnt = 0;
    pend_data = '0;
    forever begin
      @(negedge clk);
      res_valid = 1'b0;
      res_data  = '0;
      if (!rst_n) pend_cnt = 0;
      else if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          res_valid = 1'b1;
          res_data  = pend_data;
        end
      end
      cur = {op_out, a_out, b_out};
      if (!hold_mode) hold_cnt = 0;
      if (hold_mode && vec_valid && cur == 10'd5 && hold_cnt < 20) begin
        vec_ready = 1'b0;
        hold_cnt++;
      end else if (rnd_mode) vec_ready = ($urandom_range(0, 3) != 0);
      else vec_ready = 1'b1;
      if (stray_mode && vec_valid && !res_valid && $urandom_range(0, 1) == 1) begin
        res_valid = 1'b1;
        res_data  = W'($urandom);
      end
      if (rst_n && vec_valid && vec_ready) begin
        d   = ref_op(cur);
        lat = 1;
        if (fault_and0 && cur[IW-1:IW-2] == 2'd0) d[0] = 1'b0;
        if (rnd_mode) begin
          if ($urandom_range(0, 9) < 3) lat = $urandom_range(1, TMO + 1);
          if ($urandom_range(0, 63) == 0) lat = 0;
          if ($urandom_range(0, 31) == 0) d = d ^ W'($urandom_range(1, 15));
        end
        if (drop_not && cur[IW-1:IW-2] == 2'd3) lat = 0;
        pend_cnt  = lat;
        pend_data = d;
      end
    end
  end

  // Reference: one outstanding vector at a time, scored on reply or after TMO idle WAIT cycles.
  logic          m_busy, m_wait, m_done, m_pass, m_tmo;
  logic [IW-1:0] m_idx, m_ffi;
  logic [W-1:0]  m_ffd;
  logic [15:0]   m_err;
  int            m_waited;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_wait <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0; m_tmo <= 1'b0;
      m_idx <= '0; m_ffi <= '0; m_ffd <= '0; m_err <= 16'd0; m_waited <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1; m_wait <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0; m_tmo <= 1'b0;
        m_idx <= '0; m_ffi <= '0; m_ffd <= '0; m_err <= 16'd0;
      end
    end else if (!m_wait) begin
      if (vec_ready) begin
        m_wait   <= 1'b1;
        m_waited <= 0;
      end
    end else if (res_valid || m_waited == TMO) begin
      if (!res_valid || res_data != ref_op(m_idx)) begin
        if (m_err == 16'd0) begin
          m_ffi <= m_idx;
          m_ffd <= res_valid ? res_data : '0;
        end
        if (m_err != 16'hFFFF) m_err <= m_err + 16'd1;
        if (!res_valid) m_tmo <= 1'b1;
      end
      m_wait <= 1'b0;
      if (m_idx == 10'h3FF) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_pass <= (m_err == 16'd0) && res_valid && (res_data == ref_op(m_idx));
      end else m_idx <= m_idx + 10'd1;
    end else m_waited <= m_waited + 1;
  end

  // Per-cycle comparison of every DUT output against the reference.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("busy", 32'(busy), 32'(m_busy));
        check("vec_valid", 32'(vec_valid), 32'(m_busy && !m_wait));
        if (m_busy && !m_wait) check("vector", 32'({op_out, a_out, b_out}), 32'(m_idx));
        check("done", 32'(done), 32'(m_done));
        check("pass", 32'(pass), 32'(m_pass));
        check("err_count", 32'(err_count), 32'(m_err));
        check("timeout_seen", 32'(timeout_seen), 32'(m_tmo));
        check("first_fail_idx", 32'(first_fail_idx), 32'(m_ffi));
        check("first_fail_data", 32'(first_fail_data), 32'(m_ffd));
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_vec_valid"}, 32'(vec_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
    check({tag, "_tmo"}, 32'(timeout_seen), 32'd0);
    check({tag, "_ffi"}, 32'(first_fail_idx), 32'd0);
    check({tag, "_ffd"}, 32'(first_fail_data), 32'd0);
    check({tag, "_abop"}, 32'({op_out, a_out, b_out}), 32'd0);
  endtask

  // Pulse start, then count busy cycles until done; extra starts land while busy.
  task automatic run_sweep(input bit extra, output int cyc);
    bit ok;
    ok  = 1'b0;
    cyc = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 40000; n++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) cyc++;
      start = extra && busy && (cyc == 100 || cyc == 777 || cyc == 1500 || cyc == 2048);
      @(negedge clk);
    end
    start = 1'b0;
    check("sweep_finished", 32'(ok), 32'd1);
  endtask

  initial begin : main
    int  cyc;
    bit  seen;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(1'b0, cyc);
    check("golden_len", 32'(cyc), 32'd2048);
    check("golden_pass", 32'(pass), 32'd1);
    check("golden_err", 32'(err_count), 32'd0);
    check("golden_ffi", 32'(first_fail_idx), 32'd0);
    check("golden_tmo", 32'(timeout_seen), 32'd0);

    fault_and0 = 1'b1;
    run_sweep(1'b0, cyc);
    fault_and0 = 1'b0;
    check("and0_err", 32'(err_count), 32'd64);
    check("and0_model_err", 32'(m_err), 32'd64);
    check("and0_ffi", 32'(first_fail_idx), 32'h011);
    check("and0_ffd", 32'(first_fail_data), 32'h0);
    check("and0_pass", 32'(pass), 32'd0);

    drop_not = 1'b1;
    run_sweep(1'b0, cyc);
    drop_not = 1'b0;
    check("drop_len", 32'(cyc), 32'd5888);
    check("drop_err", 32'(err_count), 32'd256);
    check("drop_tmo", 32'(timeout_seen), 32'd1);
    check("drop_ffi", 32'(first_fail_idx), 32'h300);
    check("drop_ffd", 32'(first_fail_data), 32'h0);
    check("drop_pass", 32'(pass), 32'd0);

    hold_mode = 1'b1;
    run_sweep(1'b0, cyc);
    hold_mode = 1'b0;
    check("hold_len", 32'(cyc), 32'd2068);
    check("hold_pass", 32'(pass), 32'd1);
    check("hold_tmo", 32'(timeout_seen), 32'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      if (vec_valid && {op_out, a_out, b_out} == 10'd500) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reached_vec500", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(1'b0, cyc);
    check("post_reset_len", 32'(cyc), 32'd2048);
    check("post_reset_pass", 32'(pass), 32'd1);

    stray_mode = 1'b1;
    run_sweep(1'b1, cyc);
    stray_mode = 1'b0;
    check("stray_len", 32'(cyc), 32'd2048);
    check("stray_err", 32'(err_count), 32'd0);
    check("stray_pass", 32'(pass), 32'd1);

    rnd_mode = 1'b1;
    run_sweep(1'b0, cyc);
    rnd_mode = 1'b0;
    check("random_done", 32'(done), 32'd1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
